// File: rtl/rvfi_pkg.sv
// RVFI packet types shared by the commit serializer and its buffer.
//   rvfi_instr_t   : one retirement packet as produced by a core commit port.
//   rvfi_stamped_t : a buffered packet plus its retire order number and capture cycle.
package rvfi_pkg;

  typedef struct packed {
    logic        valid;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [31:0] insn;
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
  } rvfi_instr_t;

  typedef struct packed {
    rvfi_instr_t instr;
    logic [63:0] order;
    logic [63:0] cycle;
  } rvfi_stamped_t;

  // A port slot carries an entry when it retired or trapped.
  function automatic logic is_qualifying(rvfi_instr_t e);
    return e.valid | e.trap;
  endfunction

endpackage

// File: rtl/rvfi_mwsr_fifo.sv
// Multi-write, single-read FIFO of stamped RVFI packets.
// Up to NrWrite entries are pushed per cycle from data_i[0..push_cnt_i-1], all-or-nothing:
// if push_cnt_i exceeds free_o nothing is written. Pop is single-entry and ignored when empty.
//   push_cnt_i : number of entries to push this cycle (compacted at data_i[0..])
//   data_i     : entries to push, oldest first
//   free_o     : free slots at cycle start (DEPTH - occupancy)
//   pop_i      : remove head this cycle
//   head_o     : head entry (contents undefined when empty_o)
//   empty_o    : no entries buffered
module rvfi_mwsr_fifo
  import rvfi_pkg::*;
#(
  parameter int unsigned NrWrite = 2,
  parameter int unsigned Depth   = 8,
  localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned PtrW   = $clog2(Depth) + 1,
  localparam int unsigned CntW   = $clog2(NrWrite + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [CntW-1:0] push_cnt_i,
  input  rvfi_stamped_t data_i [NrWrite],
  output logic [PtrW-1:0] free_o,
  input  logic          pop_i,
  output rvfi_stamped_t head_o,
  output logic          empty_o
);

  rvfi_stamped_t   mem [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] occupancy;
  logic            push_ok;
  logic            pop_fire;

  // Pointers carry one extra wrap bit; the storage slot is the pointer modulo Depth.
  function automatic logic [AddrW-1:0] slot(logic [PtrW-1:0] p);
    return AddrW'(p & PtrW'(Depth - 1));
  endfunction

  always_comb begin
    occupancy = wptr_q - rptr_q;
    free_o    = PtrW'(Depth) - occupancy;
    empty_o   = (occupancy == '0);
    push_ok   = (32'(push_cnt_i) <= 32'(free_o));
    pop_fire  = pop_i && !empty_o;
    wptr_d    = push_ok ? wptr_q + PtrW'(push_cnt_i) : wptr_q;
    rptr_d    = pop_fire ? rptr_q + PtrW'(1) : rptr_q;
    head_o    = mem[slot(rptr_q)];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; stale contents are masked by empty_o downstream.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      for (int unsigned i = 0; i < NrWrite; i++) begin
        if (i < 32'(push_cnt_i)) begin
          mem[slot(wptr_q + PtrW'(i))] <= data_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serializes a multi-port RVFI commit interface into one valid/ready stream in program order.
// Each qualifying entry is stamped with a retire order number and the capture cycle.
//   rvfi_i     : per-port commit packets, port 0 oldest
//   valid_o    : head entry available
//   ready_i    : consumer accepts head
//   rvfi_o     : head packet ('0 when !valid_o)
//   order_o    : retire order number of head
//   cycle_o    : cycle counter value when head was captured
//   overflow_o : sticky, set on first dropped capture
//   drop_cnt_o : dropped entries, saturating
module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output rvfi_instr_t                       rvfi_o,
  output logic [63:0]                       order_o,
  output logic [63:0]                       cycle_o,
  output logic                              overflow_o,
  output logic [31:0]                       drop_cnt_o
);

  localparam int unsigned CntW = $clog2(NR_COMMIT_PORTS + 1);
  localparam int unsigned PtrW = $clog2(DEPTH) + 1;

  logic [NR_COMMIT_PORTS-1:0] qual;
  logic [CntW-1:0]            pre [NR_COMMIT_PORTS];
  logic [CntW-1:0]            k;
  logic [CntW-1:0]            push_cnt;
  rvfi_stamped_t              compact [NR_COMMIT_PORTS];
  logic [PtrW-1:0]            free;
  logic                       accept;
  logic                       drop;
  rvfi_stamped_t              head;
  logic                       empty;

  logic [63:0] order_q, order_d;
  logic [63:0] cycle_q, cycle_d;
  logic        overflow_q, overflow_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [32:0] drop_sum;

  // pre[p] is the number of qualifying ports below p, i.e. its slot in the compacted batch.
  always_comb begin
    k = '0;
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      pre[p]  = k;
      qual[p] = is_qualifying(rvfi_i[p]);
      if (qual[p]) begin
        k = k + CntW'(1);
      end
    end
  end

  // Compaction: slot j takes the port whose prefix count is j; idle ports leave no gap.
  always_comb begin
    for (int unsigned j = 0; j < NR_COMMIT_PORTS; j++) begin
      compact[j] = '0;
      for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
        if (qual[p] && (32'(pre[p]) == j)) begin
          compact[j].instr = rvfi_i[p];
          compact[j].order = order_q + 64'(pre[p]);
          compact[j].cycle = cycle_q;
        end
      end
    end
  end

  // Capacity is judged on start-of-cycle free space so ready_i never reaches the push path.
  always_comb begin
    accept     = (32'(k) <= 32'(free));
    drop       = !accept;
    push_cnt   = accept ? k : '0;
    order_d    = order_q + 64'(k);
    cycle_d    = cycle_q + 64'd1;
    drop_sum   = {1'b0, drop_cnt_q} + 33'(k);
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop) begin
      drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      order_q    <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      order_q    <= order_d;
      cycle_q    <= cycle_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  rvfi_mwsr_fifo #(
    .NrWrite (NR_COMMIT_PORTS),
    .Depth   (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_cnt_i (push_cnt),
    .data_i     (compact),
    .free_o     (free),
    .pop_i      (ready_i),
    .head_o     (head),
    .empty_o    (empty)
  );

  // Head is masked so outputs read '0 while nothing is buffered.
  always_comb begin
    valid_o    = !empty;
    rvfi_o     = valid_o ? head.instr : '0;
    order_o    = valid_o ? head.order : '0;
    cycle_o    = valid_o ? head.cycle : '0;
    overflow_o = overflow_q;
    drop_cnt_o = drop_cnt_q;
  end

endmodule
